operand_fifo: RTL and testbench

Input staging buffer upstream of the datapath top level. It queues 32-bit operand words from the host side and presents the oldest word on `dout`, which drives the datapath's `in` bus. The datapath controller pops a word with `rd_en` when it consumes the operand via the data-select path. Overflow and underflow are recorded in sticky flags so the host can detect lost or invented operands.

---
 rtl/datapath_pkg.sv | 10 +
 rtl/operand_fifo_if.sv | 33 +++
 rtl/wrap_ptr.sv | 26 ++
 rtl/operand_fifo.sv | 90 +++++++++
 tb/tb_operand_fifo.sv | 164 ++++++++++++++++
 5 files changed

// File: rtl/datapath_pkg.sv
// Shared datapath constants and types. The operand FIFO and the datapath
// registers both take their word width from here so the two cannot drift.
package datapath_pkg;

    localparam int WORD_W    = 32;
    localparam int OPQ_DEPTH = 4;

    typedef logic [WORD_W-1:0] word_t;

endpackage : datapath_pkg

// File: rtl/operand_fifo_if.sv
// Operand FIFO bus. The master side is the host pushing operands together
// with the datapath controller popping them; the slave side is the FIFO.
interface operand_fifo_if
    import datapath_pkg::*;
#(
    parameter int WIDTH = WORD_W,
    parameter int DEPTH = OPQ_DEPTH
);

    localparam int CW = $clog2(DEPTH) + 1;

    logic             wr_en;
    logic [WIDTH-1:0] wr_data;
    logic             rd_en;
    logic             clr_err;
    logic [WIDTH-1:0] dout;
    logic             empty;
    logic             full;
    logic [CW-1:0]    count;
    logic             ovf;
    logic             udf;

    modport master (
        output wr_en, wr_data, rd_en, clr_err,
        input  dout, empty, full, count, ovf, udf
    );

    modport slave (
        input  wr_en, wr_data, rd_en, clr_err,
        output dout, empty, full, count, ovf, udf
    );

endinterface : operand_fifo_if

// File: rtl/wrap_ptr.sv
// Modulo-DEPTH pointer register. It advances by one on each enabled edge
// and returns to zero after DEPTH-1.
module wrap_ptr #(
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     res,
    input  logic                     inc,
    output logic [$clog2(DEPTH)-1:0] ptr
);

    localparam int AW = $clog2(DEPTH);

    // Advance the pointer, wrapping explicitly at the last slot.
    always_ff @(posedge clk or posedge res) begin
        if (res) begin
            ptr <= '0;
        end else if (inc) begin
            if (ptr == AW'(DEPTH - 1))
                ptr <= '0;
            else
                ptr <= ptr + AW'(1);
        end
    end

endmodule : wrap_ptr

// File: rtl/operand_fifo.sv
// Operand staging FIFO in front of the datapath 'in' bus. The head word is
// shown ahead on dout and forced to zero while empty. Lost pushes and
// invented pops are recorded in sticky flags that the host can clear.
module operand_fifo
    import datapath_pkg::*;
#(
    parameter int WIDTH = WORD_W,
    parameter int DEPTH = OPQ_DEPTH
) (
    input  logic           clk,
    input  logic           res,
    operand_fifo_if.slave  bus
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH) + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wp;
    logic [AW-1:0]    rp;
    logic [CW-1:0]    count;
    logic             ovf;
    logic             udf;
    logic             empty;
    logic             full;
    logic             push_ok;
    logic             pop_ok;
    logic             ovf_set;
    logic             udf_set;

    // A full FIFO still accepts a push when a pop frees a slot on the same
    // edge. A pop of an empty FIFO is dropped even alongside a push, because
    // there is no write-through path.
    assign empty   = (count == CW'(0));
    assign full    = (count == CW'(DEPTH));
    assign push_ok = bus.wr_en & (~full | bus.rd_en);
    assign pop_ok  = bus.rd_en & ~empty;
    assign ovf_set = bus.wr_en & full & ~bus.rd_en;
    assign udf_set = bus.rd_en & empty;

    wrap_ptr #(.DEPTH(DEPTH)) u_wp (
        .clk (clk),
        .res (res),
        .inc (push_ok),
        .ptr (wp)
    );

    wrap_ptr #(.DEPTH(DEPTH)) u_rp (
        .clk (clk),
        .res (res),
        .inc (pop_ok),
        .ptr (rp)
    );

    // Storage array with no reset; the empty gating on dout hides stale data.
    always_ff @(posedge clk) begin
        if (push_ok)
            mem[wp] <= bus.wr_data;
    end

    // Occupancy tracking; a simultaneous push and pop leaves it unchanged.
    always_ff @(posedge clk or posedge res) begin
        if (res) begin
            count <= '0;
        end else if (push_ok && !pop_ok) begin
            count <= count + CW'(1);
        end else if (pop_ok && !push_ok) begin
            count <= count - CW'(1);
        end
    end

    // Sticky error flags; a fresh error on the same edge beats clr_err.
    always_ff @(posedge clk or posedge res) begin
        if (res) begin
            ovf <= 1'b0;
            udf <= 1'b0;
        end else begin
            ovf <= ovf_set | (ovf & ~bus.clr_err);
            udf <= udf_set | (udf & ~bus.clr_err);
        end
    end

    assign bus.dout  = empty ? '0 : mem[rp];
    assign bus.empty = empty;
    assign bus.full  = full;
    assign bus.count = count;
    assign bus.ovf   = ovf;
    assign bus.udf   = udf;

endmodule : operand_fifo

// File: tb/tb_operand_fifo.sv
// Directed bench for operand_fifo: reset, fill with pointer wrap, overflow,
// sticky flag precedence, underflow and back-to-back streaming.
module tb_operand_fifo;
    import datapath_pkg::*;

    logic clk;
    logic res;
    int   nvec;
    int   nerr;

    operand_fifo_if #(.WIDTH(WORD_W), .DEPTH(OPQ_DEPTH)) bus ();

    operand_fifo #(.WIDTH(WORD_W), .DEPTH(OPQ_DEPTH)) dut (
        .clk (clk),
        .res (res),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one rising edge and settle away from it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        bus.wr_en   = 1'b0;
        bus.rd_en   = 1'b0;
        bus.clr_err = 1'b0;
        bus.wr_data = '0;
    endtask

    task automatic push(input logic [31:0] d);
        bus.wr_en = 1'b1; bus.wr_data = d; tick(); bus.wr_en = 1'b0;
    endtask

    task automatic pop();
        bus.rd_en = 1'b1; tick(); bus.rd_en = 1'b0;
    endtask

    task automatic test_reset();
        idle();
        res = 1'b1;
        tick();
        tick();
        res = 1'b0;
        nvec++; if (bus.count !== 3'd0) begin nerr++; $display("[TB] FAIL rst_count got %0d want 0", bus.count); end
        nvec++; if (bus.empty !== 1'b1) begin nerr++; $display("[TB] FAIL rst_empty got %b want 1", bus.empty); end
        nvec++; if (bus.full !== 1'b0) begin nerr++; $display("[TB] FAIL rst_full got %b want 0", bus.full); end
        nvec++; if (bus.dout !== 32'h0) begin nerr++; $display("[TB] FAIL rst_dout got %h want 0", bus.dout); end
        nvec++; if ({bus.ovf, bus.udf} !== 2'b00) begin nerr++; $display("[TB] FAIL rst_flags got %b want 00", {bus.ovf, bus.udf}); end
        push(32'hA);
        push(32'hB);
        nvec++; if (bus.count !== 3'd2) begin nerr++; $display("[TB] FAIL mid_count got %0d want 2", bus.count); end
        nvec++; if (bus.dout !== 32'hA) begin nerr++; $display("[TB] FAIL mid_dout got %h want a", bus.dout); end
        #2 res = 1'b1;
        #1;
        nvec++; if (bus.count !== 3'd0) begin nerr++; $display("[TB] FAIL async_count got %0d want 0", bus.count); end
        nvec++; if (bus.empty !== 1'b1) begin nerr++; $display("[TB] FAIL async_empty got %b want 1", bus.empty); end
        nvec++; if (bus.dout !== 32'h0) begin nerr++; $display("[TB] FAIL async_dout got %h want 0", bus.dout); end
        #1 res = 1'b0;
        pop();
        nvec++; if (bus.udf !== 1'b1) begin nerr++; $display("[TB] FAIL rst_udf got %b want 1", bus.udf); end
        nvec++; if (bus.count !== 3'd0) begin nerr++; $display("[TB] FAIL rst_udf_count got %0d want 0", bus.count); end
        bus.clr_err = 1'b1; tick(); bus.clr_err = 1'b0;
        nvec++; if (bus.udf !== 1'b0) begin nerr++; $display("[TB] FAIL clr_udf got %b want 0", bus.udf); end
    endtask

    task automatic test_fill_wrap();
        logic [31:0] exp_q [4] = '{32'h3, 32'h4, 32'h5, 32'h6};
        for (int i = 1; i <= 4; i++) push(32'(i));
        nvec++; if (bus.full !== 1'b1) begin nerr++; $display("[TB] FAIL fill_full got %b want 1", bus.full); end
        nvec++; if (bus.count !== 3'd4) begin nerr++; $display("[TB] FAIL fill_count got %0d want 4", bus.count); end
        nvec++; if (bus.dout !== 32'h1) begin nerr++; $display("[TB] FAIL fill_head got %h want 1", bus.dout); end
        pop();
        pop();
        nvec++; if (bus.dout !== 32'h3) begin nerr++; $display("[TB] FAIL pop2_head got %h want 3", bus.dout); end
        nvec++; if (bus.count !== 3'd2) begin nerr++; $display("[TB] FAIL pop2_count got %0d want 2", bus.count); end
        push(32'h5);
        push(32'h6);
        nvec++; if (bus.full !== 1'b1) begin nerr++; $display("[TB] FAIL wrap_full got %b want 1", bus.full); end
        for (int i = 0; i < 4; i++) begin
            nvec++; if (bus.dout !== exp_q[i]) begin nerr++; $display("[TB] FAIL wrap_order[%0d] got %h want %h", i, bus.dout, exp_q[i]); end
            pop();
        end
        nvec++; if (bus.empty !== 1'b1) begin nerr++; $display("[TB] FAIL drain_empty got %b want 1", bus.empty); end
        nvec++; if (bus.dout !== 32'h0) begin nerr++; $display("[TB] FAIL drain_dout got %h want 0", bus.dout); end
        nvec++; if ({bus.ovf, bus.udf} !== 2'b00) begin nerr++; $display("[TB] FAIL wrap_flags got %b want 00", {bus.ovf, bus.udf}); end
    endtask

    task automatic test_overflow();
        logic [31:0] exp_q [4] = '{32'h12, 32'h13, 32'hFF, 32'h0};
        for (int i = 0; i < 4; i++) push(32'h10 + 32'(i));
        push(32'hFF);
        nvec++; if (bus.ovf !== 1'b1) begin nerr++; $display("[TB] FAIL ovf_set got %b want 1", bus.ovf); end
        nvec++; if (bus.count !== 3'd4) begin nerr++; $display("[TB] FAIL ovf_count got %0d want 4", bus.count); end
        nvec++; if (bus.dout !== 32'h10) begin nerr++; $display("[TB] FAIL ovf_head got %h want 10", bus.dout); end
        bus.wr_en = 1'b1; bus.rd_en = 1'b1; bus.wr_data = 32'hFF;
        tick();
        idle();
        nvec++; if (bus.ovf !== 1'b1) begin nerr++; $display("[TB] FAIL ovf_keep got %b want 1", bus.ovf); end
        nvec++; if (bus.count !== 3'd4) begin nerr++; $display("[TB] FAIL rw_full_count got %0d want 4", bus.count); end
        nvec++; if (bus.dout !== 32'h11) begin nerr++; $display("[TB] FAIL rw_full_head got %h want 11", bus.dout); end
        for (int i = 0; i < 4; i++) begin
            pop();
            nvec++; if (bus.dout !== exp_q[i]) begin nerr++; $display("[TB] FAIL ovf_order[%0d] got %h want %h", i, bus.dout, exp_q[i]); end
        end
        nvec++; if (bus.udf !== 1'b0) begin nerr++; $display("[TB] FAIL ovf_no_udf got %b want 0", bus.udf); end
    endtask

    task automatic test_sticky();
        bus.clr_err = 1'b1; tick(); bus.clr_err = 1'b0;
        nvec++; if (bus.ovf !== 1'b0) begin nerr++; $display("[TB] FAIL clr_ovf got %b want 0", bus.ovf); end
        for (int i = 0; i < 4; i++) push(32'h20 + 32'(i));
        bus.clr_err = 1'b1; bus.wr_en = 1'b1; bus.wr_data = 32'h99;
        tick();
        idle();
        nvec++; if (bus.ovf !== 1'b1) begin nerr++; $display("[TB] FAIL set_beats_clr got %b want 1", bus.ovf); end
        nvec++; if (bus.dout !== 32'h20) begin nerr++; $display("[TB] FAIL sticky_head got %h want 20", bus.dout); end
        bus.clr_err = 1'b1; tick(); bus.clr_err = 1'b0;
        for (int i = 0; i < 4; i++) pop();
        nvec++; if ({bus.empty, bus.ovf, bus.udf} !== 3'b100) begin nerr++; $display("[TB] FAIL sticky_end got %b want 100", {bus.empty, bus.ovf, bus.udf}); end
    endtask

    task automatic test_underflow();
        bus.wr_en = 1'b1; bus.rd_en = 1'b1; bus.wr_data = 32'h55;
        tick();
        idle();
        nvec++; if (bus.udf !== 1'b1) begin nerr++; $display("[TB] FAIL udf_set got %b want 1", bus.udf); end
        nvec++; if (bus.count !== 3'd1) begin nerr++; $display("[TB] FAIL udf_count got %0d want 1", bus.count); end
        nvec++; if (bus.dout !== 32'h55) begin nerr++; $display("[TB] FAIL udf_dout got %h want 55", bus.dout); end
        bus.clr_err = 1'b1; bus.rd_en = 1'b1; tick(); idle();
        nvec++; if ({bus.empty, bus.udf} !== 2'b10) begin nerr++; $display("[TB] FAIL udf_clear got %b want 10", {bus.empty, bus.udf}); end
    endtask

    task automatic test_back_to_back();
        push(32'h100);
        for (int i = 1; i <= 20; i++) begin
            bus.wr_en = 1'b1; bus.rd_en = 1'b1; bus.wr_data = 32'h100 + 32'(i);
            nvec++; if (bus.dout !== 32'h100 + 32'(i - 1)) begin nerr++; $display("[TB] FAIL stream_head[%0d] got %h want %h", i, bus.dout, 32'h100 + 32'(i - 1)); end
            tick();
            nvec++; if (bus.count !== 3'd1) begin nerr++; $display("[TB] FAIL stream_count[%0d] got %0d want 1", i, bus.count); end
        end
        idle();
        nvec++; if (bus.dout !== 32'h114) begin nerr++; $display("[TB] FAIL stream_last got %h want 114", bus.dout); end
        nvec++; if ({bus.ovf, bus.udf} !== 2'b00) begin nerr++; $display("[TB] FAIL stream_flags got %b want 00", {bus.ovf, bus.udf}); end
    endtask

    initial begin
        nvec = 0;
        nerr = 0;
        test_reset();
        test_fill_wrap();
        test_overflow();
        test_sticky();
        test_underflow();
        test_back_to_back();
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule : tb_operand_fifo
